// File: rtl/stream_mux_pkg.sv
// Shared types for the stream multiplexer: arbitration state and select mode.
// Latency/backpressure: n/a (types only).
package stream_mux_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef enum logic {
        MODE_SEL,
        MODE_RR
    } mode_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin pick: first requesting channel at or above ptr, wrapping to 0.
// Latency: combinational. Backpressure: none, the caller qualifies the grant.
module rr_arbiter #(
    parameter int N_CH  = 7,
    parameter int SEL_W = $clog2(N_CH + 1)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    localparam int              PAD_N = 2 ** SEL_W;
    localparam logic [SEL_W:0]  N_EXT = (SEL_W + 1)'(N_CH);

    logic [PAD_N-1:0] req_pad;
    logic [SEL_W:0]   cand;

    assign req_pad = PAD_N'(req);

    // Walk offsets from far to near so the nearest requester is the last writer.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (req_pad[cand[SEL_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream mux with explicit/round-robin select and packet lock.
// Latency: 1 cycle, one output register stage, 1 beat/cycle sustained.
// Backpressure: inputs are only accepted when the output register is empty or draining.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               N_CH        = 7,
    parameter int               SEL_W       = $clog2(N_CH + 1),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = 16'd42
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH-1:0]         in_last,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready,
    output logic                    sel_err
);

    localparam int               PAD_N   = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] N_CH_S  = SEL_W'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               sel_err_q, sel_err_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;

    logic [PAD_N-1:0]   in_valid_pad;
    logic [SEL_W-1:0]   rr_idx;
    logic               rr_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic               grant_vld;
    logic               sel_bad;
    logic               load;
    logic               accept;
    logic [WIDTH-1:0]   acc_data;
    logic               acc_last;

    assign in_valid_pad = PAD_N'(in_valid);
    assign load         = !out_valid_q || out_ready;
    assign accept       = load && grant_vld && !rst;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // A locked packet owns the output until its last beat; mode and sel are ignored.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        sel_bad   = 1'b0;
        if (state_q == LOCKED) begin
            grant_idx = lock_ch_q;
            grant_vld = in_valid_pad[lock_ch_q];
        end else if (mode_t'(mode) == MODE_SEL) begin
            if (sel < N_CH_S) begin
                grant_idx = sel;
                grant_vld = in_valid_pad[sel];
            end else begin
                sel_bad = 1'b1;
            end
        end else begin
            grant_idx = rr_idx;
            grant_vld = rr_vld;
        end
    end

    always_comb begin
        acc_data = '0;
        acc_last = 1'b0;
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                acc_data    = in_data[i*WIDTH +: WIDTH];
                acc_last    = in_last[i];
                in_ready[i] = accept;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = sel_err_q | sel_bad;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            out_data_d  = acc_data;
            out_last_d  = acc_last;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            if (acc_last) begin
                state_d  = IDLE;
                rr_ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
            end else begin
                state_d   = LOCKED;
                lock_ch_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
            sel_err_q   <= 1'b0;
            out_data_q  <= DEFAULT_VAL;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_err_q   <= sel_err_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Parametrised, registered N-channel stream multiplexer with valid/ready handshakes; next generation of the fixed 7:1 combinational mux.
- Adds configurable width and channel count, an explicit-select or round-robin mode, packet locking on a last flag, and a one-stage registered output.
- Sits between several producer streams and a single consumer.

Parameters:
- WIDTH, 16, data bits per channel.
- N_CH, 7, number of input channels (>=1).
- SEL_W, $clog2(N_CH+1), select/channel-index width; always able to encode an out-of-range value.
- DEFAULT_VAL, 16'd42, out_data value after reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N_CH*WIDTH  flattened channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  in  N_CH  per-channel valid.
- in_last  in  N_CH  per-channel end-of-packet flag.
- in_ready  out  N_CH  per-channel ready.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SEL_W  channel index used in mode 0.
- out_data  out  WIDTH  registered data.
- out_valid  out  1  output valid.
- out_last  out  1  registered last flag.
- out_ch  out  SEL_W  source channel of the current out_data.
- out_ready  in  1  consumer ready.
- sel_err  out  1  sticky out-of-range select flag.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_last=0, out_ch=0, out_data=DEFAULT_VAL, state=IDLE, rr_ptr=0, sel_err=0. in_ready is all-zero while rst=1.
- Load enable: load = !out_valid || out_ready.
- Input transfer: on channel i when in_valid[i] && in_ready[i]. Output transfer: when out_valid && out_ready.
- in_ready[i] = load && (grant == i). At most one bit of in_ready is ever set.
- Accepted beat: registers data, last and channel index next cycle; out_valid=1. Latency is 1 cycle. Throughput is 1 beat/cycle with out_ready held high.
- Output hold: with out_valid=1 and out_ready=0, out_* stay stable and no input is accepted.
- State IDLE, mode 0:
  - sel < N_CH: grant = sel if in_valid[sel], else none.
  - sel >= N_CH: no grant; sel_err is set and stays set until reset.
- State IDLE, mode 1: grant = first valid channel searching from rr_ptr upward, wrapping N_CH-1 to 0. No valid channel means no grant.
- Leaving IDLE: an accepted beat with in_last=0 moves to LOCKED and stores lock_ch. An accepted beat with in_last=1 stays in IDLE (single-beat packet).
- State LOCKED:
  - grant = lock_ch only when in_valid[lock_ch]; mode and sel are ignored.
  - An accepted beat with in_last=1 returns to IDLE.
- Round-robin pointer: on every accepted last beat, in either mode, rr_ptr = (ch+1) mod N_CH. At ch = N_CH-1 it wraps to 0.
- Simultaneous events:
  - Input accept and output drain in the same cycle is allowed; the register is overwritten and out_valid stays 1.
  - A change of mode or sel while LOCKED takes effect only after the packet ends.
- Reset mid-packet: lock is dropped, the pending output beat is discarded, and the remainder of the packet is treated as a new packet.
- N_CH=1: round-robin degenerates to channel 0; rr_ptr stays 0.

Decomposition:
- Package stream_mux_pkg holds:
  - typedef enum logic {IDLE, LOCKED} state_t;
  - typedef enum logic {MODE_SEL, MODE_RR} mode_t.
- Sub-module rr_arbiter is purely combinational, parametrised by N_CH. Inputs are req[N_CH] and ptr; outputs are gnt_idx and gnt_vld.

Test Plan:
- Reset/default: assert rst for 2 cycles, then release with all in_valid=0 -> out_data=42, out_valid=0, sel_err=0, in_ready=0.
- Explicit select: mode=0, sel=2, ch2 sends 0x1234 with last=1, out_ready=1 -> in_ready=7'b0000100; next cycle out_data=0x1234, out_ch=2, out_last=1.
- Out of range: mode=0, sel=7 (N_CH=7), all channels valid -> no in_ready asserted; sel_err=1 and stays 1 after sel returns to 0.
- Round-robin fairness: mode=1, ch0/3/6 always valid with single-beat packets -> grants in order 0,3,6,0,3 (6 wraps back to 0).
- Packet lock under backpressure: ch1 sends 3 beats, last on beat 3; ch0 also valid; toggle sel and mode mid-packet; out_ready toggles 1,0,1 -> beats emerge in order with no ch0 interleave and stable data while stalled; ch0 is granted only after the ch1 last beat.
